// File: rtl/encoder_prio_pipe.sv
// Registered N-to-log2(N) priority encoder with valid/ready handshake, zero/multi-hot flags
// and a saturating multi-hot counter. Define ENCODER_ROUND_ROBIN_EN for rotating priority.
module encoder_prio_pipe #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_zero,
  output logic             out_multi,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;
  logic             req_zero;
  logic             req_multi;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign req_zero  = ~|in_req;
  assign req_multi = |(in_req & (in_req - N'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (out_ready && !in_valid) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   pos;

  // Search ascending from ptr, wrapping N-1 -> 0; the first hit wins.
  always_comb begin
    enc_idx   = '0;
    enc_found = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      if (!enc_found && in_req[pos[IDX_W-1:0]]) begin
        enc_idx   = pos[IDX_W-1:0];
        enc_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && !req_zero) begin
      ptr <= (enc_idx == IDX_W'(N-1)) ? '0 : enc_idx + IDX_W'(1);
    end
  end
`else
  always_comb begin
    enc_idx   = '0;
    enc_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!enc_found && in_req[i]) begin
        enc_idx   = IDX_W'(i);
        enc_found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_idx   <= '0;
      out_zero  <= 1'b0;
      out_multi <= 1'b0;
      err_cnt   <= '0;
    end else if (accept) begin
      out_idx   <= enc_idx;
      out_zero  <= req_zero;
      out_multi <= req_multi;
      if (req_multi && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
